player_move_seq: RTL and testbench
==================================

// Module: player_move_seq
// PURPOSE
//  Parametrised successor to the player movement FSM. Decodes a 3-bit move request and sequences
//  calc / load / draw strobes to the player datapath for walks and multi-phase jumps.
//  Jump length (phase count) is a parameter. Optional calc_done handshake replaces the fixed
//  one-cycle calc slot. A land input ends a jump early. Sits between game-tick control and the
//  player position datapath / VGA drawer.
// PARAMETERS
//  JUMP_PHASES  4  phases per jump, legal 2..8; first half rises, second half falls
//  CALC_HS      1  1: wait for calc_done after each calc_go; 0: fixed 1-cycle calc slot
//  OP_W         4  width of calc_op
//  PH_W         3  width of phase output; must satisfy 2**PH_W >= JUMP_PHASES
// PORTS
//  clock      in   1     system clock, rising edge
//  resetn     in   1     asynchronous active-low reset
//  go         in   1     tick: starts a move in IDLE, releases the next phase in PHASE_WAIT
//  move       in   3     100 L, 110 jump L, 010 jump up, 011 jump R, 001 R, other = none
//  calc_done  in   1     datapath finished the last calc_op (used only when CALC_HS=1)
//  land       in   1     ground contact; sampled only in PHASE_WAIT
//  calc_op    out  OP_W  datapath op; valid only while calc_go=1, else 0
//  calc_go    out  1     one-cycle calc request
//  load_p     out  1     one-cycle load of calculated position
//  draw       out  1     one-cycle redraw request
//  move_done  out  1     one-cycle end-of-phase / end-of-move pulse
//  busy       out  1     1 in every state except IDLE
//  phase      out  PH_W  current jump phase index, 0 outside jumps
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, latched move=000, phase=0, all outputs 0.
//  - Outputs are Moore-decoded from the state register. Each strobe is high exactly one cycle per visit.
//  - IDLE: go=1 -> DECODE. In DECODE, move is latched; later changes to move are ignored until IDLE.
//  - Per-phase sequence: [VCALC] -> [HCALC] -> LOAD -> DRAW -> DONE.
//     - VCALC is present only for jumps; HCALC only for moves with a horizontal part.
//     - No-move: DRAW -> DONE only.
//  - Op codes:
//     - H: RIGHT=0000, LEFT=0001.
//     - V, phase p with H=JUMP_PHASES/2:
//        - p=0: RISE_BIG=0101; 0<p<H: RISE_SMALL=0011
//        - p=JUMP_PHASES-1: FALL_BIG=0100; H<=p<last: FALL_SMALL=0010
//     - JUMP_PHASES=4 gives 0101, 0011, 0010, 0100.
//  - Handshake, CALC_HS=1:
//     - After each calc_go cycle, FSM sits in CALC_WAIT until calc_done=1.
//     - calc_done in the same cycle as calc_go is ignored.
//     - No timeout.
//  - Handshake, CALC_HS=0: the calc state advances unconditionally after one cycle; calc_done is ignored.
//  - DONE: move_done=1. Next state:
//     - jump and phase < JUMP_PHASES-1: PHASE_WAIT, phase increments;
//     - otherwise: IDLE, phase=0.
//  - PHASE_WAIT: busy=1, no strobes.
//     - land=1: IDLE (no extra move_done); land has priority over go.
//     - else go=1: next phase.
//  - go outside IDLE / PHASE_WAIT is ignored (no queuing).
//  - go held high through the final DONE cycle starts a new move one cycle after reaching IDLE.
//  - Latency: walk go -> move_done = 5 cycles with CALC_HS=0 (DECODE, HCALC, LOAD, DRAW, DONE);
//    jump-L/R phase = 5 cycles after release, 6 for the first phase.
//  - Every state, including unused encodings, has a defined next state; illegal encodings -> IDLE.
//  - Reset mid-operation: immediate IDLE, no move_done emitted.
// STRUCTURE
//  - Package player_pkg:
//     - op code localparams (OP_RIGHT, OP_LEFT, OP_RISE_BIG, OP_RISE_SMALL, OP_FALL_SMALL, OP_FALL_BIG);
//     - move code localparams (MV_LEFT, MV_JUMP_L, MV_JUMP_UP, MV_JUMP_R, MV_RIGHT);
//     - state encoding.
//  - One sub-module: player_jump_profile, combinational (phase, JUMP_PHASES) -> vertical calc_op.
//  - Main module holds the FSM, move latch and phase counter.
// TESTING
//  1. CALC_HS=0, move=001, go pulse
//     -> calc_go+calc_op=0000 cycle 2, load_p cycle 3, draw cycle 4, move_done cycle 5, then IDLE.
//  2. CALC_HS=0, JUMP_PHASES=4, move=110, go each time in PHASE_WAIT
//     -> V ops 0101, 0011, 0010, 0100, each followed by 0001; 4 move_done pulses; phase 0..3.
//  3. CALC_HS=1, move=011, calc_done delayed 3 cycles per calc
//     -> FSM holds in CALC_WAIT; no load_p before 2nd calc_done; calc_done during calc_go ignored.
//  4. JUMP_PHASES=6, move=010, land=1 together with go in PHASE_WAIT after phase 2
//     -> IDLE, busy=0, phase=0, no further calc_go, exactly 3 move_done total.
//  5. move=101, go -> draw then move_done, no calc_go/load_p. resetn=0 mid-jump (in LOAD)
//     -> all outputs 0 asynchronously, IDLE, move change during a walk has no effect.
//  6. go held high continuously, move=001
//     -> back-to-back walks, one move_done per 6 cycles, no lost or double strobes.

Source files
------------

// File: rtl/player_pkg.sv
// Shared constants for the player movement sequencer: datapath op codes,
// move request codes, FSM state encoding and the move-request decoder.
package player_pkg;

    localparam logic [3:0] OP_RIGHT      = 4'b0000;
    localparam logic [3:0] OP_LEFT       = 4'b0001;
    localparam logic [3:0] OP_FALL_SMALL = 4'b0010;
    localparam logic [3:0] OP_RISE_SMALL = 4'b0011;
    localparam logic [3:0] OP_FALL_BIG   = 4'b0100;
    localparam logic [3:0] OP_RISE_BIG   = 4'b0101;

    localparam logic [2:0] MV_RIGHT   = 3'b001;
    localparam logic [2:0] MV_JUMP_UP = 3'b010;
    localparam logic [2:0] MV_JUMP_R  = 3'b011;
    localparam logic [2:0] MV_LEFT    = 3'b100;
    localparam logic [2:0] MV_JUMP_L  = 3'b110;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DECODE     = 4'd1;
    localparam logic [3:0] ST_VCALC      = 4'd2;
    localparam logic [3:0] ST_VWAIT      = 4'd3;
    localparam logic [3:0] ST_HCALC      = 4'd4;
    localparam logic [3:0] ST_HWAIT      = 4'd5;
    localparam logic [3:0] ST_LOAD       = 4'd6;
    localparam logic [3:0] ST_DRAW       = 4'd7;
    localparam logic [3:0] ST_DONE       = 4'd8;
    localparam logic [3:0] ST_PHASE_WAIT = 4'd9;

    typedef struct packed {
        logic jump;
        logic horiz;
        logic left;
    } move_kind_t;

    // Unknown request codes decode to "no move": draw only.
    function automatic move_kind_t decode_move(input logic [2:0] mv);
        move_kind_t k;
        k = '0;
        case (mv)
            MV_LEFT:    begin k.horiz = 1'b1; k.left = 1'b1; end
            MV_JUMP_L:  begin k.jump = 1'b1; k.horiz = 1'b1; k.left = 1'b1; end
            MV_JUMP_UP: k.jump = 1'b1;
            MV_JUMP_R:  begin k.jump = 1'b1; k.horiz = 1'b1; end
            MV_RIGHT:   k.horiz = 1'b1;
            default:    k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/player_jump_profile.sv
// Vertical op for a jump phase: big rise, small rises, small falls, big fall.
module player_jump_profile
    import player_pkg::*;
#(
    parameter int JUMP_PHASES = 4,
    parameter int PH_W        = 3,
    parameter int OP_W        = 4
) (
    input  logic [PH_W-1:0] phase,
    output logic [OP_W-1:0] v_op
);

    localparam logic [PH_W-1:0] HALF = PH_W'(JUMP_PHASES / 2);
    localparam logic [PH_W-1:0] LAST = PH_W'(JUMP_PHASES - 1);

    always_comb begin
        if (phase == '0)
            v_op = OP_W'(OP_RISE_BIG);
        else if (phase < HALF)
            v_op = OP_W'(OP_RISE_SMALL);
        else if (phase == LAST)
            v_op = OP_W'(OP_FALL_BIG);
        else
            v_op = OP_W'(OP_FALL_SMALL);
    end

endmodule

// File: rtl/player_move_seq.sv
// Player movement sequencer: decodes a move request and emits calc / load /
// draw strobes for walks and multi-phase jumps, with optional calc handshake.
module player_move_seq
    import player_pkg::*;
#(
    parameter int JUMP_PHASES = 4,
    parameter int CALC_HS     = 1,
    parameter int OP_W        = 4,
    parameter int PH_W        = 3
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            go,
    input  logic [2:0]      move,
    input  logic            calc_done,
    input  logic            land,
    output logic [OP_W-1:0] calc_op,
    output logic            calc_go,
    output logic            load_p,
    output logic            draw,
    output logic            move_done,
    output logic            busy,
    output logic [PH_W-1:0] phase
);

    localparam logic [PH_W-1:0] LAST = PH_W'(JUMP_PHASES - 1);
    localparam bit HS = (CALC_HS != 0);

    logic [3:0]      state, state_nxt;
    logic [2:0]      move_q;
    logic [PH_W-1:0] phase_q;
    logic [OP_W-1:0] v_op;
    logic [3:0]      after_v;
    move_kind_t      kind;

    // DECODE steers on the live request; every later state uses the latched copy.
    assign kind    = decode_move((state == ST_DECODE) ? move : move_q);
    assign after_v = kind.horiz ? ST_HCALC : ST_LOAD;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:       state_nxt = go ? ST_DECODE : ST_IDLE;
            ST_DECODE:     state_nxt = kind.jump  ? ST_VCALC :
                                       kind.horiz ? ST_HCALC : ST_DRAW;
            ST_VCALC:      state_nxt = HS ? ST_VWAIT : after_v;
            ST_VWAIT:      state_nxt = calc_done ? after_v : ST_VWAIT;
            ST_HCALC:      state_nxt = HS ? ST_HWAIT : ST_LOAD;
            ST_HWAIT:      state_nxt = calc_done ? ST_LOAD : ST_HWAIT;
            ST_LOAD:       state_nxt = ST_DRAW;
            ST_DRAW:       state_nxt = ST_DONE;
            ST_DONE:       state_nxt = (kind.jump && phase_q < LAST) ? ST_PHASE_WAIT : ST_IDLE;
            ST_PHASE_WAIT: state_nxt = land ? ST_IDLE : (go ? ST_VCALC : ST_PHASE_WAIT);
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            move_q  <= '0;
            phase_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of its peers.
            state <= state_nxt;
            if (state == ST_DECODE)
                move_q <= move;
            if (state_nxt == ST_IDLE)
                phase_q <= '0;
            else if (state == ST_DONE && state_nxt == ST_PHASE_WAIT)
                phase_q <= phase_q + PH_W'(1);
        end
    end

    player_jump_profile #(
        .JUMP_PHASES (JUMP_PHASES),
        .PH_W        (PH_W),
        .OP_W        (OP_W)
    ) u_profile (
        .phase (phase_q),
        .v_op  (v_op)
    );

    // Moore outputs: a reset forces them low immediately through the state register.
    assign calc_go   = (state == ST_VCALC) || (state == ST_HCALC);
    assign calc_op   = (state == ST_VCALC) ? v_op :
                       (state == ST_HCALC) ? (kind.left ? OP_W'(OP_LEFT) : OP_W'(OP_RIGHT)) :
                       '0;
    assign load_p    = (state == ST_LOAD);
    assign draw      = (state == ST_DRAW);
    assign move_done = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign phase     = phase_q;

endmodule

// File: tb/tb_player_move_seq.sv
// Scoreboard bench: dut0 is JUMP_PHASES=4 without handshake, dut1 is
// JUMP_PHASES=6 with a calc_done responder that answers three cycles late.
module tb_player_move_seq;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    logic       go0 = 1'b0, cd0 = 1'b0, land0 = 1'b0;
    logic [2:0] move0 = 3'b000;
    logic [3:0] op0;
    logic       cg0, lp0, dr0, md0, busy0;
    logic [2:0] ph0;

    logic       go1 = 1'b0, cd1 = 1'b0, land1 = 1'b0;
    logic [2:0] move1 = 3'b000;
    logic [3:0] op1;
    logic       cg1, lp1, dr1, md1, busy1;
    logic [2:0] ph1;

    player_move_seq #(.JUMP_PHASES(4), .CALC_HS(0), .OP_W(4), .PH_W(3)) dut0 (
        .clock(clock), .resetn(resetn), .go(go0), .move(move0), .calc_done(cd0),
        .land(land0), .calc_op(op0), .calc_go(cg0), .load_p(lp0), .draw(dr0),
        .move_done(md0), .busy(busy0), .phase(ph0)
    );

    player_move_seq #(.JUMP_PHASES(6), .CALC_HS(1), .OP_W(4), .PH_W(3)) dut1 (
        .clock(clock), .resetn(resetn), .go(go1), .move(move1), .calc_done(cd1),
        .land(land1), .calc_op(op1), .calc_go(cg1), .load_p(lp1), .draw(dr1),
        .move_done(md1), .busy(busy1), .phase(ph1)
    );

    always #5 clock = ~clock;

    // Strobe vector layout: {calc_go, load_p, draw, move_done}
    localparam logic [3:0] S_CALC = 4'b1000;
    localparam logic [3:0] S_LOAD = 4'b0100;
    localparam logic [3:0] S_DRAW = 4'b0010;
    localparam logic [3:0] S_DONE = 4'b0001;

    typedef struct {
        logic [3:0] strb;
        logic [3:0] op;
        logic [2:0] ph;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc    = 0;
    int n_run  = 0;
    int n_fail = 0;
    int done0  = 0;
    int done1  = 0;
    int cd_cnt = 0;

    logic [3:0] vop4 [4];
    logic [3:0] vop6 [6];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int which, input logic [3:0] strb, input logic [3:0] op,
                        input logic [2:0] ph, input int c);
        exp_t e;
        e.strb = strb; e.op = op; e.ph = ph; e.cyc = c;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Expected events for one phase; w = extra cycles each calc waits for calc_done.
    task automatic push_seq(input int which, input bit has_v, input logic [3:0] vop,
                            input bit has_h, input logic [3:0] hop, input logic [2:0] ph,
                            input int t_first, input int w, output int t_done);
        int t;
        t = t_first;
        if (has_v) begin push(which, S_CALC, vop, ph, t); t += 1 + w; end
        if (has_h) begin push(which, S_CALC, hop, ph, t); t += 1 + w; end
        if (has_v || has_h) begin push(which, S_LOAD, 4'b0, ph, t); t++; end
        push(which, S_DRAW, 4'b0, ph, t);
        push(which, S_DONE, 4'b0, ph, t + 1);
        t_done = t + 1;
    endtask

    task automatic cmp_ev(input string tag, input exp_t e, input logic [3:0] s,
                          input logic [3:0] op, input logic [2:0] ph);
        check({tag, "_strobes"}, s, e.strb);
        check({tag, "_calc_op"}, op, e.op);
        check({tag, "_phase"}, ph, e.ph);
        check({tag, "_cycle"}, cyc, e.cyc);
    endtask

    // Monitors: any strobe pops the next expected event for that DUT.
    always @(negedge clock) begin
        exp_t e;
        logic [3:0] s;
        s = {cg0, lp0, dr0, md0};
        if (s != 4'b0) begin
            if (md0) done0++;
            if (q0.size() == 0) check("dut0_unexpected_strobe", s, 4'b0);
            else begin
                e = q0.pop_front();
                cmp_ev("dut0", e, s, op0, ph0);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        logic [3:0] s;
        s = {cg1, lp1, dr1, md1};
        if (s != 4'b0) begin
            if (md1) done1++;
            if (q1.size() == 0) check("dut1_unexpected_strobe", s, 4'b0);
            else begin
                e = q1.pop_front();
                cmp_ev("dut1", e, s, op1, ph1);
            end
        end
    end

    // calc_done responder for dut1: a spurious pulse during calc_go, the real one 3 cycles later.
    initial begin
        forever begin
            @(negedge clock);
            if (cg1) begin
                cd1 = 1'b1;
                cd_cnt = 3;
            end else if (cd_cnt > 0) begin
                cd_cnt--;
                cd1 = (cd_cnt == 0);
            end else begin
                cd1 = 1'b0;
            end
        end
    end

    initial begin
        int base, t, d_start;
        vop4[0] = 4'b0101; vop4[1] = 4'b0011; vop4[2] = 4'b0010; vop4[3] = 4'b0100;
        vop6[0] = 4'b0101; vop6[1] = 4'b0011; vop6[2] = 4'b0011;
        vop6[3] = 4'b0010; vop6[4] = 4'b0010; vop6[5] = 4'b0100;

        // Reset state
        tick(2);
        check("rst_strobes0", {cg0, lp0, dr0, md0}, 4'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_op0", op0, 4'b0);
        check("rst_phase0", ph0, 3'b0);
        check("rst_strobes1", {cg1, lp1, dr1, md1, busy1}, 5'b0);
        resetn = 1'b1;
        tick(2);

        // 1: walk right, no handshake; calc_done toggling is ignored
        cd0 = 1'b1; move0 = 3'b001; go0 = 1'b1; base = cyc;
        push_seq(0, 0, 4'b0, 1, 4'b0000, 3'b0, base + 2, 0, t);
        tick(1); go0 = 1'b0;
        check("t1_busy_decode", busy0, 1'b1);
        tick(5);
        check("t1_idle", busy0, 1'b0);
        check("t1_queue_empty", q0.size(), 0);
        cd0 = 1'b0;

        // 2: four-phase jump left; move changes in PHASE_WAIT must be ignored
        d_start = done0;
        move0 = 3'b110; go0 = 1'b1; base = cyc;
        push_seq(0, 1, vop4[0], 1, 4'b0001, 3'b0, base + 2, 0, t);
        tick(1); go0 = 1'b0;
        tick(t - cyc + 2);
        for (int p = 1; p < 4; p++) begin
            check("t2_pw_busy", busy0, 1'b1);
            check("t2_pw_phase", ph0, p[2:0]);
            move0 = 3'b001;
            go0 = 1'b1; base = cyc;
            push_seq(0, 1, vop4[p], 1, 4'b0001, p[2:0], base + 1, 0, t);
            tick(1); go0 = 1'b0;
            tick(t - cyc + 2);
        end
        check("t2_idle", busy0, 1'b0);
        check("t2_phase_cleared", ph0, 3'b0);
        check("t2_move_done_count", done0 - d_start, 4);
        check("t2_queue_empty", q0.size(), 0);

        // 3: jump right with delayed calc_done, then land in PHASE_WAIT
        d_start = done1;
        move1 = 3'b011; go1 = 1'b1; base = cyc;
        push_seq(1, 1, 4'b0101, 1, 4'b0000, 3'b0, base + 2, 3, t);
        tick(1); go1 = 1'b0;
        tick(t - cyc + 2);
        check("t3_pw_busy", busy1, 1'b1);
        check("t3_pw_phase", ph1, 3'd1);
        land1 = 1'b1;
        tick(1); land1 = 1'b0;
        check("t3_land_idle", busy1, 1'b0);
        check("t3_land_phase", ph1, 3'b0);
        tick(8);
        check("t3_move_done_count", done1 - d_start, 1);
        check("t3_queue_empty", q1.size(), 0);

        // 4: six-phase jump up, land together with go after phase 2
        d_start = done1;
        move1 = 3'b010; go1 = 1'b1; base = cyc;
        push_seq(1, 1, vop6[0], 0, 4'b0, 3'b0, base + 2, 3, t);
        tick(1); go1 = 1'b0;
        tick(t - cyc + 2);
        for (int p = 1; p < 3; p++) begin
            go1 = 1'b1; base = cyc;
            push_seq(1, 1, vop6[p], 0, 4'b0, p[2:0], base + 1, 3, t);
            tick(1); go1 = 1'b0;
            tick(t - cyc + 2);
        end
        check("t4_pw_phase", ph1, 3'd3);
        land1 = 1'b1; go1 = 1'b1;
        tick(1); land1 = 1'b0; go1 = 1'b0;
        check("t4_land_idle", busy1, 1'b0);
        check("t4_land_phase", ph1, 3'b0);
        tick(10);
        check("t4_move_done_count", done1 - d_start, 3);
        check("t4_queue_empty", q1.size(), 0);

        // 5: unknown move code draws only; then reset while in LOAD
        move0 = 3'b101; go0 = 1'b1; base = cyc;
        push_seq(0, 0, 4'b0, 0, 4'b0, 3'b0, base + 2, 0, t);
        tick(1); go0 = 1'b0;
        tick(4);
        check("t5_nomove_idle", busy0, 1'b0);
        d_start = done0;
        move0 = 3'b011; go0 = 1'b1; base = cyc;
        push(0, S_CALC, 4'b0101, 3'b0, base + 2);
        push(0, S_CALC, 4'b0000, 3'b0, base + 3);
        push(0, S_LOAD, 4'b0, 3'b0, base + 4);
        tick(1); go0 = 1'b0;
        tick(3);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_strobes", {cg0, lp0, dr0, md0}, 4'b0);
        check("t5_rst_busy", busy0, 1'b0);
        check("t5_rst_op_phase", {op0, ph0}, 7'b0);
        tick(2); resetn = 1'b1;
        tick(4);
        check("t5_no_move_done", done0 - d_start, 0);
        check("t5_queue_empty", q0.size(), 0);

        // 6: go held high, back-to-back walks every 6 cycles
        d_start = done0;
        move0 = 3'b001; go0 = 1'b1; base = cyc;
        for (int k = 0; k < 3; k++)
            push_seq(0, 0, 4'b0, 1, 4'b0000, 3'b0, base + 2 + 6 * k, 0, t);
        tick(18); go0 = 1'b0;
        tick(4);
        check("t6_idle", busy0, 1'b0);
        check("t6_move_done_count", done0 - d_start, 3);
        check("t6_queue_empty", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
